// File: rtl/adsr_pkg.sv
// Shared types and default widths for the ADSR envelope / VCA stage.
package adsr_pkg;

  localparam int unsigned TICK_DIV_DEF = 1000;
  localparam int unsigned PERIOD_W_DEF = 23;
  localparam int unsigned AUDIO_W_DEF  = 24;
  localparam int unsigned ENV_W_DEF    = 18;

  localparam logic [ENV_W_DEF-1:0] ENV_MAX = {ENV_W_DEF{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/adsr_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, never restarted by note events.
module adsr_tick_gen
  import adsr_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_b,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = (cnt_r == CNT_LAST);

  // counter 0..TICK_DIV-1 with wrap
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/adsr_vca.sv
// Note event detection, ADSR envelope state machine and two-stage tone x envelope multiplier.
module adsr_vca
  import adsr_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned AUDIO_W  = AUDIO_W_DEF,
  parameter int unsigned ENV_W    = ENV_W_DEF
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [PERIOD_W-1:0] period,
  input  logic [AUDIO_W-1:0]  tone_in,
  input  logic [ENV_W-1:0]    attack_rate,
  input  logic [ENV_W-1:0]    decay_rate,
  input  logic [ENV_W-1:0]    sustain_level,
  input  logic [ENV_W-1:0]    release_rate,
  output logic [AUDIO_W-1:0]  audio_out,
  output logic [ENV_W-1:0]    env_level,
  output logic                busy
);

  localparam int unsigned PROD_W = AUDIO_W + ENV_W + 1;
  localparam logic [ENV_W-1:0] ENV_TOP  = {ENV_W{1'b1}};
  localparam logic [ENV_W-1:0] ENV_ZERO = {ENV_W{1'b0}};

  logic [PERIOD_W-1:0] period_q_r;
  logic                note_on_s, note_off_s, tick_s;
  state_t              state_r, state_nxt_s;
  logic [ENV_W-1:0]    level_r, level_nxt_s;
  logic [ENV_W:0]      att_sum_s, dec_diff_s;
  logic [AUDIO_W-1:0]  tone_p_r;
  logic [ENV_W-1:0]    env_p_r;
  logic                busy_r;
  logic [AUDIO_W-1:0]  audio_r;
  logic signed [PROD_W-1:0] tone_x_s, env_x_s, prod_s;
  logic                unused_prod_s;

  adsr_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_b (rst_b),
    .tick  (tick_s)
  );

  // A change to a different nonzero period is a (re)trigger; a drop to zero releases.
  assign note_on_s  = (period != period_q_r) && (period != {PERIOD_W{1'b0}});
  assign note_off_s = (period_q_r != {PERIOD_W{1'b0}}) && (period == {PERIOD_W{1'b0}});

  assign att_sum_s  = {1'b0, level_r} + {1'b0, attack_rate};
  assign dec_diff_s = {1'b0, level_r} - {1'b0, decay_rate};

  // next state and envelope level; events pre-empt ticks and leave the level untouched
  always_comb begin
    state_nxt_s = state_r;
    level_nxt_s = level_r;
    if (note_on_s) begin
      state_nxt_s = ST_ATTACK;
    end else if (note_off_s && (state_r != ST_IDLE) && (state_r != ST_RELEASE)) begin
      state_nxt_s = ST_RELEASE;
    end else if (tick_s) begin
      case (state_r)
        ST_ATTACK: begin
          if ((attack_rate == ENV_ZERO) || (att_sum_s >= {1'b0, ENV_TOP})) begin
            level_nxt_s = ENV_TOP;
            state_nxt_s = ST_DECAY;
          end else begin
            level_nxt_s = att_sum_s[ENV_W-1:0];
          end
        end
        ST_DECAY: begin
          if (level_r <= sustain_level) begin
            state_nxt_s = ST_SUSTAIN;
          end else if ((decay_rate == ENV_ZERO) || dec_diff_s[ENV_W] ||
                       (dec_diff_s[ENV_W-1:0] <= sustain_level)) begin
            level_nxt_s = sustain_level;
            state_nxt_s = ST_SUSTAIN;
          end else begin
            level_nxt_s = dec_diff_s[ENV_W-1:0];
          end
        end
        ST_SUSTAIN: begin
          level_nxt_s = sustain_level;
        end
        ST_RELEASE: begin
          if ((release_rate == ENV_ZERO) || (release_rate >= level_r)) begin
            level_nxt_s = ENV_ZERO;
            state_nxt_s = ST_IDLE;
          end else begin
            level_nxt_s = level_r - release_rate;
          end
        end
        ST_IDLE: begin
          level_nxt_s = ENV_ZERO;
        end
        default: begin
          level_nxt_s = ENV_ZERO;
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      level_nxt_s = level_r;
    end
  end

  // state, level, busy and period history registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r    <= ST_IDLE;
      level_r    <= ENV_ZERO;
      busy_r     <= 1'b0;
      period_q_r <= {PERIOD_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      level_r    <= level_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      period_q_r <= period;
    end
  end

  // Unsigned level is zero-extended so the signed product keeps the tone's sign.
  assign tone_x_s = {{(ENV_W+1){tone_p_r[AUDIO_W-1]}}, tone_p_r};
  assign env_x_s  = {{AUDIO_W{1'b0}}, 1'b0, env_p_r};
  assign prod_s   = tone_x_s * env_x_s;
  assign unused_prod_s = ^{prod_s[PROD_W-1], prod_s[ENV_W-1:0]};

  // two-stage multiplier pipeline; slicing above ENV_W is an arithmetic shift (floor)
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tone_p_r <= {AUDIO_W{1'b0}};
      env_p_r  <= ENV_ZERO;
      audio_r  <= {AUDIO_W{1'b0}};
    end else begin
      tone_p_r <= tone_in;
      env_p_r  <= level_r;
      audio_r  <= prod_s[ENV_W +: AUDIO_W];
    end
  end

  assign audio_out = audio_r;
  assign env_level = level_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_adsr_vca.sv
// Directed self-checking bench for adsr_vca with a 4-clock envelope tick.
module tb_adsr_vca;
  import adsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [22:0] period = 23'd0;
  logic [23:0] tone_in = 24'h400000;
  logic [17:0] attack_rate = 18'd65536;
  logic [17:0] decay_rate = 18'd16384;
  logic [17:0] sustain_level = 18'd131072;
  logic [17:0] release_rate = 18'd65536;
  logic [23:0] audio_out;
  logic [17:0] env_level;
  logic        busy;

  int total = 0;
  int bad = 0;
  int ph = 0;

  adsr_vca #(.TICK_DIV(4)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .period        (period),
    .tone_in       (tone_in),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .audio_out     (audio_out),
    .env_level     (env_level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clk_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ph = (ph + 1) % 4;
    end
    #1;
  endtask

  // advance to just after the next tick-consuming edge
  task automatic to_tick();
    bit was;
    int guard;
    was = 1'b0;
    guard = 0;
    while (!was && guard < 8) begin
      @(posedge clk);
      was = (ph == 3);
      ph = (ph + 1) % 4;
      guard++;
    end
    if (!was) chk("tick_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(dut.state_r), 32'(exp));
  endtask

  initial begin
    #12;
    chk("rst_audio", 32'(audio_out), 32'd0);
    chk("rst_env", 32'(env_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #11 rst_b = 1'b1;
    ph = 0;

    // idle with a loud tone stays silent
    clk_n(6);
    chk("idle_audio", 32'(audio_out), 32'd0);
    chk("idle_env", 32'(env_level), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // attack 0 -> 65536 x3 -> saturate
    period = 23'd100;
    clk_n(1);
    chk("on_busy", 32'(busy), 32'd1);
    chk("on_env", 32'(env_level), 32'd0);
    chk_st("on_st", ST_ATTACK);
    to_tick(); chk("att1", 32'(env_level), 32'd65536);
    to_tick(); chk("att2", 32'(env_level), 32'd131072);
    to_tick(); chk("att3", 32'(env_level), 32'd196608);
    to_tick(); chk("att4", 32'(env_level), 32'd262143);
    chk_st("att_st", ST_DECAY);

    // decay 262143 in 16384 steps, floored at 131072 on the 8th tick
    for (int i = 1; i <= 7; i++) begin
      to_tick();
      chk("decay", 32'(env_level), 32'd262143 - 32'(i) * 32'd16384);
    end
    to_tick();
    chk("dec_floor", 32'(env_level), 32'd131072);
    clk_n(1);
    chk("lat1", 32'(audio_out), 32'd16 * 32'd147455);
    clk_n(1);
    chk("lat2", 32'(audio_out), 32'h200000);
    chk_st("sus_st", ST_SUSTAIN);

    // sustain tracks live changes
    sustain_level = 18'd120000;
    to_tick(); chk("sus_live", 32'(env_level), 32'd120000);
    sustain_level = 18'd131072;
    to_tick(); chk("sus_back", 32'(env_level), 32'd131072);

    // release to idle in two ticks
    period = 23'd0;
    clk_n(1);
    chk_st("rel_st", ST_RELEASE);
    chk("rel_evt_env", 32'(env_level), 32'd131072);
    to_tick(); chk("rel1", 32'(env_level), 32'd65536);
    chk("rel1_busy", 32'(busy), 32'd1);
    to_tick(); chk("rel2", 32'(env_level), 32'd0);
    chk("rel2_busy", 32'(busy), 32'd0);
    chk_st("rel_idle", ST_IDLE);

    // retrigger mid-release keeps the level
    period = 23'd200;
    clk_n(1);
    to_tick(); to_tick();
    chk("re_att", 32'(env_level), 32'd131072);
    period = 23'd0;
    clk_n(1);
    to_tick(); chk("re_rel", 32'(env_level), 32'd65536);
    period = 23'd200;
    clk_n(1);
    chk_st("re_st", ST_ATTACK);
    chk("re_env", 32'(env_level), 32'd65536);
    to_tick(); to_tick(); to_tick();
    chk("re_top", 32'(env_level), 32'd262143);
    chk_st("re_dec", ST_DECAY);
    period = 23'd300;
    clk_n(1);
    chk_st("re2_st", ST_ATTACK);
    chk("re2_env", 32'(env_level), 32'd262143);
    to_tick();
    chk_st("re2_dec", ST_DECAY);

    // negative tones at full envelope round toward minus infinity
    tone_in = 24'h800000;
    clk_n(2);
    chk("neg_max", 32'(audio_out), 32'h800020);
    tone_in = 24'hFFFFFF;
    clk_n(2);
    chk("neg_one", 32'(audio_out), 32'hFFFFFF);

    // async reset mid-attack, then restart from a held period
    period = 23'd100;
    clk_n(1);
    chk_st("pre_rst_st", ST_ATTACK);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_audio", 32'(audio_out), 32'd0);
    chk("mid_rst_env", 32'(env_level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    #2 rst_b = 1'b1;
    ph = 0;
    tone_in = 24'h400000;
    clk_n(1);
    chk_st("post_rst_st", ST_ATTACK);
    chk("post_rst_busy", 32'(busy), 32'd1);
    to_tick(); chk("post_rst_att", 32'(env_level), 32'd65536);

    // zero rates jump straight to their targets
    attack_rate = 18'd0;
    to_tick(); chk("att0", 32'(env_level), 32'(ENV_MAX));
    decay_rate = 18'd0;
    to_tick(); chk("dec0", 32'(env_level), 32'd131072);
    chk_st("dec0_st", ST_SUSTAIN);
    period = 23'd0;
    release_rate = 18'd0;
    clk_n(1);
    to_tick(); chk("rel0", 32'(env_level), 32'd0);
    chk("rel0_busy", 32'(busy), 32'd0);
    clk_n(2);
    chk("rel0_audio", 32'(audio_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
